irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller in front of the processor's exception controller.
- Arbitrates N_SRC external level-sensitive interrupt sources and presents a single ExtIRQ to the core.
- Closes the handshake with the core (ExtIAck) and with the winning source (4-phase irq_ack), then masks further requests until the core executes ERET.

Parameters:
N_SRC, 4, number of interrupt sources (2..16)
ACK_TIMEOUT, 16, max cycles irq_ack is held waiting for source release (>=2)
ID_W, $clog2(N_SRC), width of irq_id

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
irq_req  in  N_SRC  level interrupt requests, one per source
irq_mask  in  N_SRC  1 = source enabled
ExtIAck  in  1  core has taken the external exception (from controller)
ERet  in  1  core executing ERET (from controller)
ExtIRQ  out  1  pending external interrupt to controller
irq_ack  out  N_SRC  one-hot acknowledge to the granted source
irq_id  out  ID_W  granted source index; valid while busy=1
busy  out  1  state != IDLE
in_service  out  1  state == SERVICE
ack_timeout  out  1  sticky: a source failed to release within ACK_TIMEOUT
spurious_cnt  out  8  saturating count of requests withdrawn before ExtIAck

Behaviour:
- Everything is registered; outputs change only on the clk rising edge.
- Reset (any state, any cycle): state=IDLE; ExtIRQ=0, irq_ack=0, irq_id=0, busy=0, in_service=0, ack_timeout=0, spurious_cnt=0, ack counter=0, RR pointer=0.
- FSM states: IDLE, REQ, HANDSHAKE, SERVICE.
- IDLE: eligible = irq_req & irq_mask.
  - If eligible != 0: pick a winner, latch irq_id, go to REQ. ExtIRQ=1 from the next cycle (1-cycle latency).
  - ERet and ExtIAck are ignored.
- REQ: ExtIRQ=1.
  - ExtIAck=1: go to HANDSHAKE; irq_ack[irq_id]=1 next cycle; ExtIRQ=0.
  - Else if irq_req[irq_id]=0 (withdrawn): go to IDLE, spurious_cnt++ (saturates at 255).
  - ExtIAck wins over a same-cycle withdrawal.
  - irq_mask changes after latching do not cancel the request.
- HANDSHAKE: irq_ack[irq_id]=1; counter increments each cycle.
  - irq_req[irq_id]=0: drop irq_ack, go to SERVICE.
  - Counter reaches ACK_TIMEOUT-1: drop irq_ack, set ack_timeout, go to SERVICE.
  - ERet seen here is latched (eret_seen). When HANDSHAKE exits with eret_seen=1, go to IDLE instead of SERVICE.
- SERVICE: in_service=1; all new requests are held off.
  - ERet=1: go to IDLE. A new arbitration may start the following cycle.
- The counter clears on entry to HANDSHAKE.
- irq_ack is one-hot or zero at all times.
- A request that is asserted and eligible during SERVICE becomes ExtIRQ exactly 2 cycles after ERet is sampled.

Optional Feature:
- IRQ_RR_EN defined: round-robin arbitration. Search starts at (last granted index + 1) mod N_SRC. The pointer updates only on REQ->HANDSHAKE (withdrawn grants do not rotate it).
- IRQ_RR_EN undefined: fixed priority; lowest index wins; no pointer register.

Decomposition:
- Package irq_pkg: irq_state_t enum (IDLE, REQ, HANDSHAKE, SERVICE); constant SPUR_MAX=8'hFF; EXT_IRQ_ESTATUS=4'b0001, shared with the controller.
- Sub-module irq_prio_pick (combinational): inputs eligible and start pointer; outputs winner index and valid. Fixed-priority mode ties the start pointer to 0.

Test Plan:
- N_SRC=4, mask=4'hF, irq_req=4'b0100 at cycle 0 -> ExtIRQ=1, irq_id=2 at cycle 1. ExtIAck pulse at cycle 3 -> irq_ack=4'b0100 at cycle 4. Drop irq_req[2] at cycle 6 -> irq_ack=0, in_service=1 at cycle 7. ERet at cycle 10 -> busy=0 at cycle 11.
- irq_req=4'b1010, fixed priority -> irq_id=1. After full service with req still 4'b1010: fixed priority -> irq_id=1 again; IRQ_RR_EN -> irq_id=3.
- irq_req=4'b0001 then withdrawn in REQ with no ExtIAck -> IDLE, spurious_cnt=1. Repeat 300 times -> spurious_cnt=255.
- Source holds irq_req high after ack, ACK_TIMEOUT=16 -> irq_ack high exactly 16 cycles, ack_timeout=1 (sticky), state SERVICE.
- mask=4'b0000 with irq_req=4'hF -> ExtIRQ stays 0. Also: irq_req[0] asserted during SERVICE -> ExtIRQ re-asserts 2 cycles after ERet.
- reset asserted during HANDSHAKE -> next cycle irq_ack=0, ExtIRQ=0, busy=0, ack_timeout=0, spurious_cnt=0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the external interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        HANDSHAKE = 2'd2,
        SERVICE   = 2'd3
    } irq_state_t;

    localparam logic [7:0] SPUR_MAX        = 8'hFF;
    localparam logic [3:0] EXT_IRQ_ESTATUS = 4'b0001;

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational winner search over eligible sources, starting at index `start`
// and wrapping; start tied to 0 gives plain lowest-index priority.
module irq_prio_pick #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [ID_W-1:0]  start,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    // First pass covers [start, N_SRC), second pass wraps to [0, start).
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!valid && eligible[i] && (ID_W'(i) >= start)) begin
                winner = ID_W'(i);
                valid  = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!valid && eligible[i]) begin
                winner = ID_W'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller: arbitration, core/source handshakes, ERET unmask.
// Define IRQ_RR_EN for round-robin arbitration; default is fixed priority.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned ID_W        = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_req,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             ExtIAck,
    input  logic             ERet,
    output logic             ExtIRQ,
    output logic [N_SRC-1:0] irq_ack,
    output logic [ID_W-1:0]  irq_id,
    output logic             busy,
    output logic             in_service,
    output logic             ack_timeout,
    output logic [7:0]       spurious_cnt
);

    localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

    irq_state_t       state_q, state_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       spur_q, spur_d;
    logic             ack_to_q, ack_to_d;
    logic             eret_seen_q, eret_seen_d;
    logic             ext_irq_q, ext_irq_d;
    logic [N_SRC-1:0] irq_ack_q, irq_ack_d;
    logic             busy_q, busy_d;
    logic             in_service_q, in_service_d;

    logic [N_SRC-1:0] eligible;
    logic [ID_W-1:0]  start_ptr;
    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;
    logic             req_held;

    assign eligible = irq_req & irq_mask;
    assign req_held = irq_req[irq_id_q];

`ifdef IRQ_RR_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Rotate only when a grant is actually taken by the core.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == REQ && ExtIAck) begin
            rr_ptr_d = (irq_id_q == ID_W'(N_SRC - 1)) ? '0 : irq_id_q + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign start_ptr = rr_ptr_q;
`else
    assign start_ptr = '0;
`endif

    irq_prio_pick #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_pick (
        .eligible (eligible),
        .start    (start_ptr),
        .winner   (pick_id),
        .valid    (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        irq_id_d    = irq_id_q;
        cnt_d       = cnt_q;
        spur_d      = spur_q;
        ack_to_d    = ack_to_q;
        eret_seen_d = eret_seen_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = REQ;
                    irq_id_d = pick_id;
                end
            end
            REQ: begin
                // The core's acknowledge beats a same-cycle withdrawal.
                if (ExtIAck) begin
                    state_d     = HANDSHAKE;
                    cnt_d       = '0;
                    eret_seen_d = 1'b0;
                end else if (!req_held) begin
                    state_d = IDLE;
                    if (spur_q != SPUR_MAX) spur_d = spur_q + 8'd1;
                end
            end
            HANDSHAKE: begin
                eret_seen_d = eret_seen_q | ERet;
                cnt_d       = cnt_q + CNT_W'(1);
                if (!req_held || cnt_q == CNT_LAST) begin
                    if (req_held) ack_to_d = 1'b1;
                    // An ERET already executed means there is nothing left to service.
                    state_d = (eret_seen_q || ERet) ? IDLE : SERVICE;
                end
            end
            SERVICE: begin
                if (ERet) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ext_irq_d    = (state_d == REQ);
        irq_ack_d    = (state_d == HANDSHAKE) ? (ONE_HOT0 << irq_id_d) : '0;
        busy_d       = (state_d != IDLE);
        in_service_d = (state_d == SERVICE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_id_q     <= '0;
            cnt_q        <= '0;
            spur_q       <= '0;
            ack_to_q     <= 1'b0;
            eret_seen_q  <= 1'b0;
            ext_irq_q    <= 1'b0;
            irq_ack_q    <= '0;
            busy_q       <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
            cnt_q        <= cnt_d;
            spur_q       <= spur_d;
            ack_to_q     <= ack_to_d;
            eret_seen_q  <= eret_seen_d;
            ext_irq_q    <= ext_irq_d;
            irq_ack_q    <= irq_ack_d;
            busy_q       <= busy_d;
            in_service_q <= in_service_d;
        end
    end

    assign ExtIRQ       = ext_irq_q;
    assign irq_ack      = irq_ack_q;
    assign irq_id       = irq_id_q;
    assign busy         = busy_q;
    assign in_service   = in_service_q;
    assign ack_timeout  = ack_to_q;
    assign spurious_cnt = spur_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl; expected grant ids go through a scoreboard queue.
module tb_irq_ctrl;

    localparam int unsigned N_SRC       = 4;
    localparam int unsigned ACK_TIMEOUT = 16;
    localparam int unsigned ID_W        = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N_SRC-1:0] irq_req = '0;
    logic [N_SRC-1:0] irq_mask = '0;
    logic             ExtIAck = 1'b0;
    logic             ERet = 1'b0;
    logic             ExtIRQ;
    logic [N_SRC-1:0] irq_ack;
    logic [ID_W-1:0]  irq_id;
    logic             busy;
    logic             in_service;
    logic             ack_timeout;
    logic [7:0]       spurious_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    irq_ctrl #(
        .N_SRC       (N_SRC),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .ID_W        (ID_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_req      (irq_req),
        .irq_mask     (irq_mask),
        .ExtIAck      (ExtIAck),
        .ERet         (ERet),
        .ExtIRQ       (ExtIRQ),
        .irq_ack      (irq_ack),
        .irq_id       (irq_id),
        .busy         (busy),
        .in_service   (in_service),
        .ack_timeout  (ack_timeout),
        .spurious_cnt (spurious_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for ExtIRQ, then pop the scoreboard and compare the granted id.
    task automatic expect_grant(input string tag, input int max_cyc);
        int n = 0;
        int exp_id;
        while (!ExtIRQ && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_extirq"}, 32'(ExtIRQ), 32'd1);
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_id"}, 32'(irq_id), 32'(exp_id));
    endtask

    // From REQ: core acks, source releases, service, ERET.
    task automatic take(input string tag, input int id, input logic [3:0] req_hs,
                        input logic [3:0] req_svc);
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        check({tag, "_ack"}, 32'(irq_ack), 32'(4'b0001 << id));
        irq_req = req_hs;
        step();
        check({tag, "_ack_drop"}, 32'(irq_ack), 32'd0);
        check({tag, "_insvc"}, 32'(in_service), 32'd1);
        irq_req = req_svc;
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        logic seen;

        // Reset values
        step();
        step();
        check("rst_extirq", 32'(ExtIRQ), 32'd0);
        check("rst_ack", 32'(irq_ack), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_insvc", 32'(in_service), 32'd0);
        check("rst_to", 32'(ack_timeout), 32'd0);
        check("rst_spur", 32'(spurious_cnt), 32'd0);
        reset = 1'b0;

        // Directed timeline: request, ack, release, ERET
        irq_mask = 4'hF;
        irq_req  = 4'b0100;
        exp_q.push_back(2);
        step();
        expect_grant("t1_c1", 0);
        step();
        step();
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        check("t1_ack_c4", 32'(irq_ack), 32'h4);
        check("t1_extirq_c4", 32'(ExtIRQ), 32'd0);
        step();
        step();
        irq_req = 4'b0000;
        step();
        check("t1_ack_c7", 32'(irq_ack), 32'd0);
        check("t1_insvc_c7", 32'(in_service), 32'd1);
        step();
        step();
        step();
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        check("t1_busy_c11", 32'(busy), 32'd0);

        // Arbitration order: fixed priority repeats, round-robin rotates
        irq_req = 4'b1010;
        exp_q.push_back(1);
        expect_grant("t2a", 4);
        take("t2a", 1, 4'b1000, 4'b1010);
`ifdef IRQ_RR_EN
        exp_q.push_back(3);
        expect_grant("t2b", 4);
        take("t2b", 3, 4'b0000, 4'b0000);
`else
        exp_q.push_back(1);
        expect_grant("t2b", 4);
        take("t2b", 1, 4'b0000, 4'b0000);
`endif

        // ExtIAck wins over a same-cycle withdrawal
        irq_req = 4'b0001;
        exp_q.push_back(0);
        expect_grant("t3", 4);
        ExtIAck = 1'b1;
        irq_req = 4'b0000;
        step();
        ExtIAck = 1'b0;
        check("t3_ack_wins", 32'(irq_ack), 32'h1);
        check("t3_spur", 32'(spurious_cnt), 32'd0);
        step();
        check("t3_insvc", 32'(in_service), 32'd1);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        check("t3_idle", 32'(busy), 32'd0);

        // Withdrawn requests count as spurious and saturate
        for (int i = 1; i <= 300; i++) begin
            irq_req = 4'b0001;
            step();
            if (i == 1) check("t4_req", 32'(ExtIRQ), 32'd1);
            irq_req = 4'b0000;
            step();
            if (i == 1)   check("t4_spur1", 32'(spurious_cnt), 32'd1);
            if (i == 255) check("t4_spur255", 32'(spurious_cnt), 32'd255);
        end
        check("t4_spur_sat", 32'(spurious_cnt), 32'd255);
        check("t4_idle", 32'(busy), 32'd0);

        // Source never releases: ack held exactly ACK_TIMEOUT cycles
        irq_req = 4'b0100;
        exp_q.push_back(2);
        expect_grant("t5", 4);
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        n = 0;
        while (irq_ack != 0 && n < 40) begin
            n++;
            step();
        end
        check("t5_ack_len", 32'(n), 32'(ACK_TIMEOUT));
        check("t5_to", 32'(ack_timeout), 32'd1);
        check("t5_insvc", 32'(in_service), 32'd1);
        irq_req = 4'b0000;
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_to_sticky", 32'(ack_timeout), 32'd1);

        // Fully masked requests never raise ExtIRQ
        irq_mask = 4'h0;
        irq_req  = 4'hF;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | ExtIRQ;
        end
        check("t6_masked", 32'(seen), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        // Request pending during SERVICE surfaces 2 cycles after ERET
        irq_mask = 4'hF;
        irq_req  = 4'b0001;
        exp_q.push_back(0);
        expect_grant("t7a", 4);
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        irq_req = 4'b0000;
        step();
        check("t7_insvc", 32'(in_service), 32'd1);
        irq_req = 4'b0001;
        step();
        step();
        check("t7_held", 32'(ExtIRQ), 32'd0);
        exp_q.push_back(0);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        check("t7_eret_p1", 32'(ExtIRQ), 32'd0);
        check("t7_busy_p1", 32'(busy), 32'd0);
        step();
        expect_grant("t7_eret_p2", 0);

        // Reset during HANDSHAKE clears everything next cycle
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        check("t8_hs_ack", 32'(irq_ack), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t8_ack", 32'(irq_ack), 32'd0);
        check("t8_extirq", 32'(ExtIRQ), 32'd0);
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_to", 32'(ack_timeout), 32'd0);
        check("t8_spur", 32'(spurious_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
